mem_bus_arbiter: RTL and testbench

- Shares the single-port-per-cycle 256x16 RAM and the memory-mapped I/O (LED register, switch input) between two bus masters.
- Port A is the CPU; port B is a loader/DMA master.
- Sits between the masters and RAM/I/O in the top level, and replaces the ad-hoc tri-state read mux and the LED load logic.
- Sequences each access as a 3-state FSM: arbitrate, access, respond. Arbitration is round-robin.

---
 rtl/mem_bus_arbiter_pkg.sv | 17 +
 rtl/mem_bus_arbiter_if.sv | 15 +
 rtl/mem_bus_arbiter_rr_arbiter_2.sv | 14 +
 rtl/mem_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master RAM / memory-mapped I/O arbiter:
// command codes, I/O addresses and FSM state encoding.
package mem_bus_arbiter_pkg;

    localparam logic [1:0] CMD_MWRITE = 2'b01;
    localparam logic [1:0] CMD_MREAD  = 2'b10;

    localparam logic [8:0] LED_ADDR_DEF = 9'h100;
    localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request/done handshake bundle for one bus master; the master holds req
// and its command fields stable until done pulses.
interface mem_bus_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              req;
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              done;

    modport master (output req, output cmd, output addr, output wdata, input done);
    modport slave  (input req, input cmd, input addr, input wdata, output done);
endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter_2.sv
// Combinational two-request round-robin picker; grant_sel 0 selects A, 1 selects B.
module rr_arbiter_2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic grant_valid,
    output logic grant_sel
);

    // On a tie the port that was not granted last time wins.
    assign grant_valid = req_a | req_b;
    assign grant_sel   = (req_a & req_b) ? ~last : req_b;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the 256x16 RAM, LED register and switch input between a CPU (port A)
// and a loader (port B) via an arbitrate / access / respond FSM.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 9,
    parameter int                RAM_AW   = 8,
    parameter logic [ADDR_W-1:0] LED_ADDR = LED_ADDR_DEF,
    parameter logic [ADDR_W-1:0] SW_ADDR  = SW_ADDR_DEF,
    parameter int                SW_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_if.slave          a_bus,
    mem_bus_if.slave          b_bus,
    output logic [DATA_W-1:0] rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic [SW_W-1:0]   sw_in,
    output logic [SW_W-1:0]   led_out,
    output logic              owner
);

    state_e            r_state;
    logic              r_owner;
    logic [1:0]        r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ram_write;
    logic              r_a_done;
    logic              r_b_done;
    logic [SW_W-1:0]   r_led;
    logic [SW_W-1:0]   r_sw;

    logic              w_grant_valid;
    logic              w_grant_sel;
    logic [1:0]        w_cmd;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;

    rr_arbiter_2 u_rr (
        .req_a       (a_bus.req),
        .req_b       (b_bus.req),
        .last        (r_owner),
        .grant_valid (w_grant_valid),
        .grant_sel   (w_grant_sel)
    );

    assign w_cmd   = w_grant_sel ? b_bus.cmd   : a_bus.cmd;
    assign w_addr  = w_grant_sel ? b_bus.addr  : a_bus.addr;
    assign w_wdata = w_grant_sel ? b_bus.wdata : a_bus.wdata;

    // Requests only feed register inputs, so no req reaches an output combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b1;
            r_cmd       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_ram_write <= 1'b0;
            r_a_done    <= 1'b0;
            r_b_done    <= 1'b0;
            r_led       <= '0;
            r_sw        <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register sees pre-edge values.
            r_ram_write <= 1'b0;
            r_a_done    <= 1'b0;
            r_b_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner     <= w_grant_sel;
                        r_cmd       <= w_cmd;
                        r_addr      <= w_addr;
                        r_wdata     <= w_wdata;
                        r_ram_write <= (w_cmd == CMD_MWRITE) && !w_addr[ADDR_W-1];
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_cmd == CMD_MWRITE && r_addr == LED_ADDR)
                        r_led <= r_wdata[SW_W-1:0];
                    if (r_cmd == CMD_MREAD && r_addr == SW_ADDR)
                        r_sw <= sw_in;
                    r_a_done <= ~r_owner;
                    r_b_done <= r_owner;
                    r_state  <= ST_RESP;
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // RAM read data arrives one cycle after ACCESS, so the read mux is combinational in RESP.
    always_comb begin
        // NOTE: default assignment first so this block can never infer a latch.
        w_rdata = '0;
        if (r_state == ST_RESP && r_cmd == CMD_MREAD) begin
            if (!r_addr[ADDR_W-1])
                w_rdata = ram_dout;
            else if (r_addr == SW_ADDR)
                w_rdata = DATA_W'(r_sw);
        end
    end

    assign rdata      = w_rdata;
    assign ram_addr   = r_addr[RAM_AW-1:0];
    assign ram_write  = r_ram_write;
    assign ram_din    = r_wdata;
    assign led_out    = r_led;
    assign owner      = r_owner;
    assign a_bus.done = r_a_done;
    assign b_bus.done = r_b_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transactions push expected
// responses and RAM writes; a negedge monitor pops and compares them.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    typedef struct {
        bit          port;
        logic [15:0] rdata;
    } resp_t;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] din;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] rdata;
    logic [7:0]  ram_addr;
    logic        ram_write;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [7:0]  sw_in;
    logic [7:0]  led_out;
    logic        owner;

    logic [15:0] mem [256];
    resp_t       sb_q[$];
    wr_t         wr_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    mem_bus_if #(.ADDR_W(9), .DATA_W(16)) a_bus ();
    mem_bus_if #(.ADDR_W(9), .DATA_W(16)) b_bus ();

    mem_bus_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .rdata     (rdata),
        .ram_addr  (ram_addr),
        .ram_write (ram_write),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with one-cycle registered read, read-before-write.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        ram_dout = 16'h0000;
    end
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every done pulse and every RAM write against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (a_bus.done && b_bus.done) check("both_done", 1, 0);
            if (a_bus.done || b_bus.done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", {a_bus.done, b_bus.done}, 0);
                end else begin
                    resp_t e;
                    e = sb_q.pop_front();
                    check("done_port", b_bus.done, e.port);
                    check("rdata", rdata, e.rdata);
                    check("owner", owner, e.port);
                end
            end
            if (ram_write) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_ram_write", ram_addr, 0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("ram_addr", ram_addr, w.addr);
                    check("ram_din", ram_din, w.din);
                end
            end
        end
    end

    task automatic drive(input bit port, input logic [1:0] cmd, input logic [8:0] addr,
                         input logic [15:0] wdata, input logic req);
        if (!port) begin
            a_bus.cmd = cmd; a_bus.addr = addr; a_bus.wdata = wdata; a_bus.req = req;
        end else begin
            b_bus.cmd = cmd; b_bus.addr = addr; b_bus.wdata = wdata; b_bus.req = req;
        end
    endtask

    // One transaction from an idle arbiter: done is expected exactly 2 edges after req.
    task automatic run_txn(input bit port, input logic [1:0] cmd, input logic [8:0] addr,
                           input logic [15:0] wdata, input logic [15:0] exp_rdata,
                           input bit exp_write);
        int lat;
        resp_t e;
        wr_t w;
        lat = 0;
        @(posedge clk); #1;
        e.port = port; e.rdata = exp_rdata;
        sb_q.push_back(e);
        if (exp_write) begin
            w.addr = addr[7:0]; w.din = wdata;
            wr_q.push_back(w);
        end
        drive(port, cmd, addr, wdata, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if ((port ? b_bus.done : a_bus.done) === 1'b1) begin
                lat = i;
                break;
            end
        end
        drive(port, cmd, addr, wdata, 1'b0);
        check("latency", lat, 2);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        resp_t e;
        wr_t   w;
        int    t_prev;
        int    seen;

        drive(1'b0, 2'b00, 9'h000, 16'h0000, 1'b0);
        drive(1'b1, 2'b00, 9'h000, 16'h0000, 1'b0);
        sw_in = 8'h00;

        // Reset state
        @(negedge clk);
        check("rst_ram_write", ram_write, 0);
        check("rst_a_done", a_bus.done, 0);
        check("rst_b_done", b_bus.done, 0);
        check("rst_rdata", rdata, 0);
        check("rst_led", led_out, 0);
        check("rst_owner", owner, 1);
        check("rst_ram_addr", ram_addr, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset asserted during ACCESS of a B write: dropped, no done
        @(posedge clk); #1;
        w.addr = 8'h05; w.din = 16'h5555;
        wr_q.push_back(w);
        drive(1'b1, CMD_MWRITE, 9'h005, 16'h5555, 1'b1);
        @(posedge clk); #1;
        check("acc_ram_write", ram_write, 1);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check("midrst_ram_write", ram_write, 0);
        check("midrst_a_done", a_bus.done, 0);
        check("midrst_b_done", b_bus.done, 0);
        check("midrst_led", led_out, 0);
        check("midrst_state", dut.r_state, ST_IDLE);
        drive(1'b1, 2'b00, 9'h000, 16'h0000, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        check("midrst_no_write_mem05", mem[5], 16'h0000);

        // A write then read
        run_txn(1'b0, CMD_MWRITE, 9'h010, 16'hBEEF, 16'h0000, 1'b1);
        run_txn(1'b0, CMD_MREAD,  9'h010, 16'h0000, 16'hBEEF, 1'b0);

        // LED write: no RAM write, led updated
        run_txn(1'b0, CMD_MWRITE, 9'h100, 16'h12A5, 16'h0000, 1'b0);
        check("led_value", led_out, 8'hA5);

        // Switch read and unmapped I/O read
        sw_in = 8'h3C;
        run_txn(1'b1, CMD_MREAD, 9'h140, 16'h0000, 16'h003C, 1'b0);
        run_txn(1'b1, CMD_MREAD, 9'h180, 16'h0000, 16'h0000, 1'b0);

        // Write to the switch address is dropped but completes
        run_txn(1'b0, CMD_MWRITE, 9'h140, 16'h0077, 16'h0000, 1'b0);
        check("led_unchanged", led_out, 8'hA5);

        // Invalid commands leave RAM untouched
        run_txn(1'b0, CMD_MWRITE, 9'h020, 16'h1234, 16'h0000, 1'b1);
        run_txn(1'b0, 2'b11,      9'h020, 16'hFFFF, 16'h0000, 1'b0);
        run_txn(1'b1, 2'b00,      9'h020, 16'hAAAA, 16'h0000, 1'b0);
        run_txn(1'b0, CMD_MREAD,  9'h020, 16'h0000, 16'h1234, 1'b0);

        // Tie after reset: A, B, A, B every 3 cycles
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e.port = k[0];
            e.rdata = k[0] ? 16'h1234 : 16'hBEEF;
            sb_q.push_back(e);
        end
        drive(1'b0, CMD_MREAD, 9'h010, 16'h0000, 1'b1);
        drive(1'b1, CMD_MREAD, 9'h020, 16'h0000, 1'b1);
        t_prev = cyc;
        for (int k = 0; k < 4; k++) begin
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (a_bus.done === 1'b1 || b_bus.done === 1'b1) begin
                    seen = 1;
                    break;
                end
            end
            check("tie_done_seen", seen, 1);
            check("tie_spacing", cyc - t_prev, (k == 0) ? 2 : 3);
            t_prev = cyc;
        end
        drive(1'b0, 2'b00, 9'h000, 16'h0000, 1'b0);
        drive(1'b1, 2'b00, 9'h000, 16'h0000, 1'b0);

        repeat (6) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);
        check("wr_drained", wr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
